// File: rtl/sram_arbiter_pkg.sv
// Shared definitions for the SRAM arbiter slice.
//   - default address/data widths (ADDRESS_LEN / REGISTER_LEN) and watchdog limit
//   - FSM state encoding (state_t), also exported on the arbiter's debug port
//   - transaction op encoding (op_t)
package sram_arbiter_pkg;

  localparam int ADDRESS_LEN     = 32;
  localparam int REGISTER_LEN    = 32;
  localparam int DEFAULT_TIMEOUT = 15;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ISSUE = 2'b01,
    ST_WAIT  = 2'b10,
    ST_DONE  = 2'b11
  } state_t;

  typedef enum logic {
    OP_RD = 1'b0,
    OP_WR = 1'b1
  } op_t;

endpackage

// File: rtl/sram_arbiter_rr_arbiter2.sv
// Combinational two-way round-robin pick.
//   req[1:0]   in  pending request per port
//   last_grant in  port served most recently
//   grant      out chosen port (meaningful only when any=1)
//   any        out at least one request pending
// On a tie the port that was not served last wins; a lone requester always wins.
module rr_arbiter2 (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       grant,
  output logic       any
);

  always_comb begin
    any   = |req;
    grant = 1'b0;
    if (req == 2'b11) begin
      grant = ~last_grant;
    end else if (req[1]) begin
      grant = 1'b1;
    end
  end

endmodule

// File: rtl/sram_arbiter.sv
// Two-port arbiter in front of the single SRAM controller.
// Port 0 is instruction fetch, port 1 is the memory stage. One request at a
// time is latched, forwarded to the controller, and completed with a one-cycle
// p_ready pulse to the served port. A watchdog aborts a hung controller.
//
// Ports:
//   clk, rst            clock (rising edge), asynchronous active-high reset
//   p_rd[1:0], p_wr[1:0] per-port read/write request levels (rd wins if both)
//   p_addr0/1, p_wdata0/1 per-port address and write data
//   p_rdata             read data, valid in the served port's p_ready cycle
//   p_ready[1:0]        per-port ready; 0 freezes that pipeline stage
//   m_rd_en, m_wr_en    request enables toward the controller
//   m_addr, m_wdata     address / write data toward the controller
//   m_rdata, m_ready    controller read data and ready
//   timeout_err         sticky watchdog flag, cleared only by rst
//   dbg_state           current FSM state
//
// Handshake: a port raises p_rd/p_wr and holds it until it sees p_ready=1 on
// the same port; that cycle completes the transaction (and carries p_rdata for
// reads). Toward the controller the enables are held from ISSUE through WAIT;
// m_ready=1 during WAIT completes it. m_ready during ISSUE is the controller's
// idle level, not a completion, and is ignored.
module sram_arbiter
  import sram_arbiter_pkg::*;
#(
  parameter int ADDR_W  = ADDRESS_LEN,
  parameter int DATA_W  = REGISTER_LEN,
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        p_rd,
  input  logic [1:0]        p_wr,
  input  logic [ADDR_W-1:0] p_addr0,
  input  logic [ADDR_W-1:0] p_addr1,
  input  logic [DATA_W-1:0] p_wdata0,
  input  logic [DATA_W-1:0] p_wdata1,
  output logic [DATA_W-1:0] p_rdata,
  output logic [1:0]        p_ready,
  output logic              m_rd_en,
  output logic              m_wr_en,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic [DATA_W-1:0] m_rdata,
  input  logic              m_ready,
  output logic              timeout_err,
  output state_t            dbg_state
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  state_t            state_q, state_d;
  logic              grant_q, grant_d;
  logic              last_q, last_d;
  op_t               op_q, op_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [CNT_W-1:0]  wdog_q, wdog_d;
  logic              terr_q, terr_d;

  logic [1:0] pending;
  logic       pick;
  logic       pick_any;

  assign pending = p_rd | p_wr;

  rr_arbiter2 u_rr (
    .req        (pending),
    .last_grant (last_q),
    .grant      (pick),
    .any        (pick_any)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      grant_q <= 1'b0;
      last_q  <= 1'b1;          // port 0 wins the first tie
      op_q    <= OP_RD;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      wdog_q  <= '0;
      terr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      wdog_q  <= wdog_d;
      terr_q  <= terr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    op_d    = op_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    wdog_d  = wdog_q;
    terr_d  = terr_q;
    unique case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          grant_d = pick;
          op_d    = p_rd[pick] ? OP_RD : OP_WR;
          addr_d  = pick ? p_addr1 : p_addr0;
          wdata_d = pick ? p_wdata1 : p_wdata0;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        wdog_d  = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (m_ready) begin
          if (op_q == OP_RD) rdata_d = m_rdata;
          state_d = ST_DONE;
        end else if (wdog_q == CNT_W'(TIMEOUT)) begin
          // Abort: the requester is released with zero data and the
          // sticky flag tells software the controller stopped answering.
          terr_d = 1'b1;
          if (op_q == OP_RD) rdata_d = '0;
          state_d = ST_DONE;
        end else begin
          wdog_d = wdog_q + CNT_W'(1);
        end
      end
      ST_DONE: begin
        last_d  = grant_q;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Enables follow the registered state, so an asynchronous reset drops them
  // in the same cycle.
  assign m_rd_en     = ((state_q == ST_ISSUE) || (state_q == ST_WAIT)) && (op_q == OP_RD);
  assign m_wr_en     = ((state_q == ST_ISSUE) || (state_q == ST_WAIT)) && (op_q == OP_WR);
  assign m_addr      = addr_q;
  assign m_wdata     = wdata_q;
  assign p_rdata     = rdata_q;
  assign timeout_err = terr_q;
  assign dbg_state   = state_q;

  assign p_ready[0] = ~pending[0] | ((state_q == ST_DONE) && (grant_q == 1'b0));
  assign p_ready[1] = ~pending[1] | ((state_q == ST_DONE) && (grant_q == 1'b1));

endmodule

// File: tb/tb_sram_arbiter.sv
module tb_sram_arbiter;
  import sram_arbiter_pkg::*;

  localparam int TIMEOUT = 15;

  // ---------------- clock / reset / DUT ----------------
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  p_rd = '0, p_wr = '0;
  logic [31:0] p_addr0 = '0, p_addr1 = '0, p_wdata0 = '0, p_wdata1 = '0;
  logic [31:0] p_rdata;
  logic [1:0]  p_ready;
  logic        m_rd_en, m_wr_en;
  logic [31:0] m_addr, m_wdata;
  logic [31:0] m_rdata = '0;
  logic        m_ready = 1'b1;
  logic        timeout_err;
  state_t      dbg_state;

  always #5 clk = ~clk;

  sram_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .p_rd(p_rd), .p_wr(p_wr),
    .p_addr0(p_addr0), .p_addr1(p_addr1), .p_wdata0(p_wdata0), .p_wdata1(p_wdata1),
    .p_rdata(p_rdata), .p_ready(p_ready),
    .m_rd_en(m_rd_en), .m_wr_en(m_wr_en), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rdata(m_rdata), .m_ready(m_ready), .timeout_err(timeout_err), .dbg_state(dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int failures = 0;
  logic [65:0] exp_q[$];            // {rd_en, wr_en, addr, wdata} expected at the controller
  logic [31:0] ctrl_mem [logic [31:0]];
  logic [31:0] ref_mem  [logic [31:0]];
  int  lat = 1;
  bit  hang = 1'b0;
  bit  chk_ctrl = 1'b0;
  int  ccnt = 0;
  int  ctrl_ops = 0;

  task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] rd_default(input logic [31:0] a);
    return a ^ 32'h5A5A0F0F;
  endfunction

  // ---------------- SRAM controller model ----------------
  // Looks idle (ready high) in the first enabled cycle, then completes
  // lat cycles after the enables first appear, unless hang is set.
  always @(negedge clk) begin
    if (rst || !(m_rd_en || m_wr_en)) begin
      ccnt = 0;
      m_ready = 1'b1;
    end else begin
      ccnt++;
      if (ccnt == 1) begin
        m_ready = 1'b1;
      end else if (!hang && ccnt == lat + 1) begin
        m_ready = 1'b1;
        ctrl_ops++;
        if (m_wr_en) ctrl_mem[m_addr] = m_wdata;
        else m_rdata = ctrl_mem.exists(m_addr) ? ctrl_mem[m_addr] : rd_default(m_addr);
        if (chk_ctrl) begin
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL ctrl_txn: got unexpected transaction addr 0x%0h expected none", m_addr);
          end else begin
            check("ctrl_txn", {m_rd_en, m_wr_en, m_addr, m_wdata}, exp_q.pop_front());
          end
        end
      end else begin
        m_ready = 1'b0;
      end
    end
  end

  // ---------------- vector table ----------------
  typedef struct {
    logic [1:0]  rd, wr;
    logic [31:0] a0, a1, d0, d1;
    int          lat;
    bit          hang;
    int          exp_port;
    logic        exp_rd_en, exp_wr_en;
    logic [31:0] exp_addr, exp_wdata, exp_rdata;
    int          exp_cycles;
    logic        exp_terr;
  } vec_t;

  // Called at posedge+1 with the DUT idle; returns at posedge+1.
  task automatic serve_one(input vec_t v, input string tag);
    int cyc = 0, en_cnt = 0, viol = 0, got_port = -1;
    logic [1:0] req;
    lat = v.lat; hang = v.hang;
    p_rd = v.rd; p_wr = v.wr;
    p_addr0 = v.a0; p_addr1 = v.a1; p_wdata0 = v.d0; p_wdata1 = v.d1;
    req = v.rd | v.wr;
    while (got_port < 0 && cyc < 60) begin
      @(negedge clk); #1;
      cyc++;
      if (cyc == 2) begin
        check({tag, " issue_rd_en"}, m_rd_en, v.exp_rd_en);
        check({tag, " issue_wr_en"}, m_wr_en, v.exp_wr_en);
        check({tag, " issue_addr"}, m_addr, v.exp_addr);
        check({tag, " issue_wdata"}, m_wdata, v.exp_wdata);
      end
      if (m_rd_en || m_wr_en) en_cnt++;
      for (int j = 0; j < 2; j++) if (!req[j] && !p_ready[j]) viol++;
      if ((req & p_ready) == 2'b11) viol++;
      for (int j = 0; j < 2; j++) if (req[j] && p_ready[j]) got_port = j;
    end
    check({tag, " port"}, 80'(got_port), 80'(v.exp_port));
    check({tag, " cycles"}, 80'(cyc), 80'(v.exp_cycles));
    check({tag, " enable_cycles"}, 80'(en_cnt), 80'(v.exp_cycles - 2));
    check({tag, " ready_violations"}, 80'(viol), 80'(0));
    if (v.exp_rd_en) check({tag, " p_rdata"}, p_rdata, v.exp_rdata);
    check({tag, " timeout_err"}, timeout_err, v.exp_terr);
    @(posedge clk); #1;
    p_rd = '0; p_wr = '0; hang = 1'b0;
    @(negedge clk); #1;
    check({tag, " back_idle"}, dbg_state, ST_IDLE);
    @(posedge clk); #1;
  endtask

  // ---------------- randomized run against a transaction-level model ----------------
  task automatic run_random(input int lv, input int ncyc);
    bit          act[2] = '{0, 0};
    bit          done_seen[2] = '{0, 0};
    logic        rq_rd[2], rq_wr[2];
    logic [31:0] rq_a[2], rq_d[2];
    bit          busy = 0;
    int          mport = 0, done_c = 0, last = 1;
    logic        mrd = 0;
    logic [31:0] ma = '0, md = '0, er;
    int          kind;
    lat = lv; hang = 1'b0;
    rst = 1'b1; @(posedge clk); #1; rst = 1'b0;
    chk_ctrl = 1'b1;
    for (int i = 0; i < 2; i++) begin rq_rd[i] = 0; rq_wr[i] = 0; rq_a[i] = '0; rq_d[i] = '0; end
    for (int c = 0; c < ncyc + 80; c++) begin
      @(posedge clk); #1;
      for (int i = 0; i < 2; i++) begin
        if (!act[i] || done_seen[i]) begin
          done_seen[i] = 0;
          if (c < ncyc && $urandom_range(0, 99) < (act[i] ? 50 : 30)) begin
            kind = $urandom_range(1, 3);
            act[i] = 1; rq_rd[i] = kind[0]; rq_wr[i] = kind[1];
            rq_a[i] = 32'h1000 + 32'($urandom_range(0, 7)) * 4;
            rq_d[i] = $urandom;
          end else begin
            act[i] = 0; rq_rd[i] = 0; rq_wr[i] = 0;
            rq_a[i] = $urandom; rq_d[i] = $urandom;
          end
        end
      end
      p_rd = {rq_rd[1], rq_rd[0]}; p_wr = {rq_wr[1], rq_wr[0]};
      p_addr0 = rq_a[0]; p_addr1 = rq_a[1]; p_wdata0 = rq_d[0]; p_wdata1 = rq_d[1];
      @(negedge clk); #1;
      for (int i = 0; i < 2; i++)
        check($sformatf("rnd p_ready%0d c%0d", i, c), p_ready[i],
              !act[i] || (busy && c == done_c && mport == i));
      if (busy && c == done_c) begin
        if (mrd) begin
          er = ref_mem.exists(ma) ? ref_mem[ma] : rd_default(ma);
          check($sformatf("rnd p_rdata c%0d", c), p_rdata, er);
        end else begin
          ref_mem[ma] = md;
        end
        last = mport; busy = 0; done_seen[mport] = act[mport];
      end else if (!busy && (act[0] || act[1])) begin
        mport = (act[0] && act[1]) ? 1 - last : (act[1] ? 1 : 0);
        mrd = rq_rd[mport]; ma = rq_a[mport]; md = rq_d[mport];
        busy = 1; done_c = c + lv + 2;
        exp_q.push_back({mrd, !mrd, ma, md});
      end
      if (c >= ncyc && !busy && !act[0] && !act[1]) break;
    end
    p_rd = '0; p_wr = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rnd exp_q_drained", 80'(exp_q.size()), 80'(0));
    chk_ctrl = 1'b0;
    exp_q.delete();
  endtask

  // ---------------- main test ----------------
  initial begin
    vec_t vecs[8];
    vec_t fresh;
    int cyc, viol, en, got, n_done, ops0;
    int ord[4];
    bit wr_checked;

    ctrl_mem[32'h400] = 32'hDEADBEEF;

    vecs[0] = '{2'b01, 2'b00, 32'h400, 32'h0, 32'hCAFE0000, 32'h0, 6, 1'b0,
                0, 1'b1, 1'b0, 32'h400, 32'hCAFE0000, 32'hDEADBEEF, 9, 1'b0};
    vecs[1] = '{2'b00, 2'b10, 32'h0, 32'h404, 32'h0, 32'h12345678, 1, 1'b0,
                1, 1'b0, 1'b1, 32'h404, 32'h12345678, 32'h0, 4, 1'b0};
    vecs[2] = '{2'b11, 2'b00, 32'h10, 32'h20, 32'h0, 32'h0, 2, 1'b0,
                0, 1'b1, 1'b0, 32'h10, 32'h0, rd_default(32'h10), 5, 1'b0};
    vecs[3] = '{2'b10, 2'b11, 32'h30, 32'h404, 32'hAAAA5555, 32'h0, 3, 1'b0,
                1, 1'b1, 1'b0, 32'h404, 32'h0, 32'h12345678, 6, 1'b0};
    vecs[4] = '{2'b01, 2'b01, 32'h30, 32'h0, 32'h0, 32'h0, 3, 1'b0,
                0, 1'b1, 1'b0, 32'h30, 32'h0, rd_default(32'h30), 6, 1'b0};
    vecs[5] = '{2'b00, 2'b11, 32'h50, 32'h60, 32'h1, 32'h2, 1, 1'b0,
                1, 1'b0, 1'b1, 32'h60, 32'h2, 32'h0, 4, 1'b0};
    vecs[6] = '{2'b11, 2'b00, 32'h70, 32'h74, 32'h0, 32'h0, 1, 1'b0,
                0, 1'b1, 1'b0, 32'h70, 32'h0, rd_default(32'h70), 4, 1'b0};
    vecs[7] = '{2'b01, 2'b00, 32'h80, 32'h0, 32'h0, 32'h0, 1, 1'b1,
                0, 1'b1, 1'b0, 32'h80, 32'h0, 32'h0, TIMEOUT + 4, 1'b1};

    // Reset state
    p_rd = 2'b01; p_wr = 2'b10;
    repeat (2) @(posedge clk);
    #1;
    check("rst p_ready_pending", p_ready, 2'b00);
    check("rst m_rd_en", m_rd_en, 1'b0);
    check("rst m_wr_en", m_wr_en, 1'b0);
    check("rst m_addr", m_addr, 32'h0);
    check("rst m_wdata", m_wdata, 32'h0);
    check("rst p_rdata", p_rdata, 32'h0);
    check("rst timeout_err", timeout_err, 1'b0);
    check("rst state", dbg_state, ST_IDLE);
    p_rd = '0; p_wr = '0; #1;
    check("rst p_ready_idle", p_ready, 2'b11);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    for (int k = 0; k < 8; k++) serve_one(vecs[k], $sformatf("vec%0d", k));

    // rd+wr on port 1, address changes during WAIT; timeout_err must still be set
    lat = 5; p_rd = 2'b10; p_wr = 2'b10; p_addr1 = 32'h404; p_wdata1 = 32'h77;
    cyc = 0; viol = 0; en = 0; got = 0;
    while (!got && cyc < 40) begin
      @(negedge clk); #1;
      cyc++;
      if (cyc == 3) begin p_addr1 = 32'h999; p_wdata1 = 32'h88; end
      if (m_rd_en || m_wr_en) begin
        en++;
        if (!(m_rd_en && !m_wr_en && m_addr == 32'h404 && m_wdata == 32'h77)) viol++;
      end
      if (p_ready[1]) got = 1;
    end
    check("rdwr served", 80'(got), 80'(1));
    check("rdwr hold_violations", 80'(viol), 80'(0));
    check("rdwr enable_cycles", 80'(en), 80'(6));
    check("rdwr p_rdata", p_rdata, 32'h12345678);
    check("sticky timeout_err", timeout_err, 1'b1);
    @(posedge clk); #1;
    p_rd = '0; p_wr = '0;
    @(posedge clk); #1;

    // Reset during WAIT
    lat = 10; p_rd = 2'b01; p_addr0 = 32'h400;
    repeat (4) @(negedge clk);
    #1;
    check("rstwait pre_rd_en", m_rd_en, 1'b1);
    rst = 1'b1; #1;
    check("rstwait m_rd_en", m_rd_en, 1'b0);
    check("rstwait m_wr_en", m_wr_en, 1'b0);
    check("rstwait timeout_err", timeout_err, 1'b0);
    check("rstwait state", dbg_state, ST_IDLE);
    check("rstwait p_ready", p_ready, 2'b10);
    p_rd = '0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    fresh = '{2'b01, 2'b00, 32'h400, 32'h0, 32'h0, 32'h0, 2, 1'b0,
              0, 1'b1, 1'b0, 32'h400, 32'h0, 32'hDEADBEEF, 5, 1'b0};
    serve_one(fresh, "after_rst");

    // Request dropped mid-transaction
    lat = 4; p_wr = 2'b01; p_addr0 = 32'h88; p_wdata0 = 32'h5; ops0 = ctrl_ops;
    repeat (2) @(negedge clk);
    #1;
    p_wr = '0; #1;
    check("drop p_ready0", p_ready[0], 1'b1);
    repeat (12) @(negedge clk);
    #1;
    check("drop completed", 80'(ctrl_ops - ops0), 80'(1));
    check("drop state", dbg_state, ST_IDLE);
    @(posedge clk); #1;

    // Both ports hold requests from reset: 0,1,0,1 alternation
    rst = 1'b1; @(posedge clk); #1; rst = 1'b0;
    lat = 2; p_rd = 2'b01; p_wr = 2'b10;
    p_addr0 = 32'h400; p_addr1 = 32'h404; p_wdata0 = 32'h0; p_wdata1 = 32'h12345678;
    cyc = 0; viol = 0; n_done = 0; wr_checked = 0;
    while (n_done < 4 && cyc < 80) begin
      @(negedge clk); #1;
      cyc++;
      if (p_ready == 2'b11) viol++;
      if (m_wr_en && !wr_checked) begin
        check("contend wr_addr", m_addr, 32'h404);
        check("contend wr_wdata", m_wdata, 32'h12345678);
        check("contend wr_no_rd", m_rd_en, 1'b0);
        wr_checked = 1;
      end
      if (p_ready[0]) begin
        if (n_done == 0) check("contend p_rdata", p_rdata, 32'hDEADBEEF);
        ord[n_done] = 0; n_done++;
      end else if (p_ready[1]) begin
        ord[n_done] = 1; n_done++;
      end
    end
    check("contend grants", 80'(n_done), 80'(4));
    for (int k = 0; k < n_done; k++) check($sformatf("contend order%0d", k), 80'(ord[k]), 80'(k % 2));
    check("contend both_ready", 80'(viol), 80'(0));
    check("contend wr_seen", 80'(wr_checked), 80'(1));
    @(posedge clk); #1;
    p_rd = '0; p_wr = '0;
    repeat (6) @(posedge clk);
    #1;

    run_random(1, 300);
    run_random(3, 300);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish expected finish before 500000");
    $fatal(1, "global timeout");
  end

endmodule
